lut_sweep_ctrl: RTL and testbench

Sequencer that exhaustively evaluates a 7-input, 1-output combinational logic core (the optimized single-output benchmark netlists, ports x0..x6 / y0). It drives every input vector 0..2^NIN-1 into the core, one vector per cycle. It streams each response bit out as a truth-table write and accumulates a ones-count and an optional MISR signature. The block sits between the test/equivalence harness and the core, so original and optimized netlists can be compared by result rather than by structure.

---
 rtl/lut_sweep_ctrl.sv | 138 +++++++++++++
 tb/tb_lut_sweep_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/lut_sweep_ctrl.sv
// Exhaustive sweep sequencer for a NIN-input, single-output logic core: truth-table stream, ones-count, signature.
// Optional MISR signature enabled by defining LUT_SWEEP_MISR_EN; otherwise sig is tied to 0.
//
// state | meaning
// IDLE  | core_x parked at 0, waiting for start
// SWEEP | presenting vectors and capturing core_y (busy)
// DONE  | one-cycle done pulse, results held
module lut_sweep_ctrl #(
  parameter int NIN = 7,
  parameter int SIG_W = 16,
  parameter logic [SIG_W-1:0] POLY = 16'h1021
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             stall,
  output logic [NIN-1:0]   core_x,
  input  logic             core_y,
  output logic             tt_we,
  output logic [NIN-1:0]   tt_addr,
  output logic             tt_bit,
  output logic             busy,
  output logic             done,
  output logic [NIN:0]     ones_count,
  output logic [SIG_W-1:0] sig
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t         state, state_n;
  logic [NIN-1:0] core_x_n, tt_addr_n;
  logic [NIN:0]   ones_n;
  logic           tt_we_n, tt_bit_n;
  logic           arm, arm_n;
  logic           capture, clear;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      core_x     <= '0;
      tt_we      <= 1'b0;
      tt_addr    <= '0;
      tt_bit     <= 1'b0;
      ones_count <= '0;
      arm        <= 1'b0;
    end else begin
      state      <= state_n;
      core_x     <= core_x_n;
      tt_we      <= tt_we_n;
      tt_addr    <= tt_addr_n;
      tt_bit     <= tt_bit_n;
      ones_count <= ones_n;
      arm        <= arm_n;
    end
  end

  // The first SWEEP cycle is a settle cycle for vector 0, so capture starts two edges after start.
  always_comb begin
    state_n   = state;
    core_x_n  = core_x;
    tt_we_n   = 1'b0;
    tt_addr_n = tt_addr;
    tt_bit_n  = tt_bit;
    ones_n    = ones_count;
    arm_n     = arm;
    capture   = 1'b0;
    clear     = 1'b0;
    case (state)
      IDLE: begin
        core_x_n = '0;
        if (start && !abort) begin
          state_n = SWEEP;
          clear   = 1'b1;
          ones_n  = '0;
          arm_n   = 1'b1;
        end
      end
      SWEEP: begin
        if (abort) begin
          state_n  = IDLE;
          core_x_n = '0;
          arm_n    = 1'b0;
        end else if (!stall) begin
          if (arm) begin
            arm_n = 1'b0;
          end else begin
            capture   = 1'b1;
            tt_we_n   = 1'b1;
            tt_addr_n = core_x;
            tt_bit_n  = core_y;
            ones_n    = ones_count + {{NIN{1'b0}}, core_y};
            core_x_n  = core_x + {{(NIN-1){1'b0}}, 1'b1};
            if (core_x == {NIN{1'b1}}) state_n = DONE;
          end
        end
      end
      DONE: begin
        state_n  = IDLE;
        core_x_n = '0;
      end
      default: begin
        state_n  = IDLE;
        core_x_n = '0;
        arm_n    = 1'b0;
      end
    endcase
  end

  assign busy = (state == SWEEP);
  assign done = (state == DONE);

`ifdef LUT_SWEEP_MISR_EN
  logic [SIG_W-1:0] sig_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sig_q <= '0;
    end else if (clear) begin
      sig_q <= '0;
    end else if (capture) begin
      sig_q <= {sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? POLY : {SIG_W{1'b0}})
               ^ {{(SIG_W-1){1'b0}}, core_y};
    end
  end

  assign sig = sig_q;
`else
  logic unused_ctl;
  assign unused_ctl = capture | clear;
  assign sig = POLY & {SIG_W{1'b0}};
`endif

endmodule

// File: tb/tb_lut_sweep_ctrl.sv
// Self-checking bench for lut_sweep_ctrl: table of sweep scenarios plus abort/reset sequences,
// compared against a truth-table/MISR reference computed by looping over all vectors.
module tb_lut_sweep_ctrl;
  localparam int NIN = 7;
  localparam int SIG_W = 16;
  localparam int NV = 1 << NIN;
  localparam logic [SIG_W-1:0] POLY = 16'h1021;

  logic clk = 1'b0;
  logic rst_n, start, abort, stall, core_y;
  logic [NIN-1:0] core_x, tt_addr;
  logic tt_we, tt_bit, busy, done;
  logic [NIN:0] ones_count;
  logic [SIG_W-1:0] sig;

  int checks = 0;
  int errors = 0;
  int mode = 0;
  logic [NV-1:0] lut;

  always #5 clk = ~clk;

  lut_sweep_ctrl #(.NIN(NIN), .SIG_W(SIG_W), .POLY(POLY)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .stall(stall),
    .core_x(core_x), .core_y(core_y), .tt_we(tt_we), .tt_addr(tt_addr),
    .tt_bit(tt_bit), .busy(busy), .done(done), .ones_count(ones_count), .sig(sig)
  );

  // Core under test: 0 = const 0, 1 = x0, 2 = const 1, 3 = random truth table.
  assign core_y = (mode == 0) ? 1'b0 : (mode == 1) ? core_x[0] : (mode == 2) ? 1'b1 : lut[core_x];

  function automatic logic ref_y(int m, int v);
    case (m)
      0: return 1'b0;
      1: return v[0];
      2: return 1'b1;
      default: return lut[v];
    endcase
  endfunction

  function automatic int ref_ones(int m, int n);
    int c = 0;
    for (int v = 0; v < n; v++) c += int'(ref_y(m, v));
    return c;
  endfunction

  function automatic logic [SIG_W-1:0] ref_sig(int m);
    logic [SIG_W-1:0] s = '0;
`ifdef LUT_SWEEP_MISR_EN
    for (int v = 0; v < NV; v++) begin
      s = {s[SIG_W-2:0], 1'b0} ^ (s[SIG_W-1] ? POLY : '0) ^ {{(SIG_W-1){1'b0}}, ref_y(m, v)};
    end
`endif
    return s;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_core_x"}, core_x, 0);
    check({tag, "_tt_we"}, tt_we, 0);
    check({tag, "_tt_addr"}, tt_addr, 0);
    check({tag, "_tt_bit"}, tt_bit, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_ones"}, ones_count, 0);
    check({tag, "_sig"}, sig, 0);
  endtask

  // cyc = k means the cycle ending at edge T+k, where T is the start edge.
  task automatic run_sweep(input int stall_at, input int stall_len, input bit start_mid,
                           output int lat, output int n_we);
    int cyc, rem, exp_addr;
    bit stalled, got_done;
    rem = stall_len; exp_addr = 0; n_we = 0; lat = -1; stalled = 0; got_done = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; cyc = 1;
    check("busy_after_start", busy, 1);
    while (cyc < 400) begin
      if (stalled) begin
        check("stall_hold_x", core_x, stall_at);
        check("stall_no_we", tt_we, 0);
      end
      if (tt_we) begin
        check("tt_addr", tt_addr, exp_addr);
        check("tt_bit", tt_bit, ref_y(mode, exp_addr));
        exp_addr++; n_we++;
      end
      if (done) begin
        lat = cyc; got_done = 1'b1;
        break;
      end
      stall = 1'b0; stalled = 1'b0; start = 1'b0;
      if (busy && int'(core_x) == stall_at && rem > 0) begin
        stall = 1'b1; stalled = 1'b1; rem--;
      end
      if (start_mid && busy && core_x == 7'd50) start = 1'b1;
      @(negedge clk); cyc++;
    end
    stall = 1'b0; start = 1'b0;
    check("done_seen", got_done, 1);
  endtask

  task automatic wait_x(input int target);
    int n = 0;
    while (int'(core_x) != target && n < 400) begin
      @(negedge clk); n++;
    end
    check("reach_vector", core_x, target);
  endtask

  task automatic full_result_checks(input string tag, input int lat, input int n_we, input int exp_lat);
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_strobes"}, n_we, NV);
    check({tag, "_ones"}, ones_count, ref_ones(mode, NV));
    check({tag, "_sig"}, sig, ref_sig(mode));
    @(negedge clk);
    check({tag, "_x_back_0"}, core_x, 0);
    check({tag, "_idle"}, busy, 0);
    check({tag, "_done_1cyc"}, done, 0);
    check({tag, "_ones_hold"}, ones_count, ref_ones(mode, NV));
  endtask

  typedef struct {
    int mode;
    int stall_at;
    int stall_len;
    bit start_mid;
    int exp_ones;
    int exp_lat;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int lat, n_we, dcnt;
    lut = {$urandom, $urandom, $urandom, $urandom};
    vecs[0] = '{0, -1, 0, 1'b0, 0, NV + 2};
    vecs[1] = '{1, -1, 0, 1'b0, 64, NV + 2};
    vecs[2] = '{2, -1, 0, 1'b0, 128, NV + 2};
    vecs[3] = '{1, 40, 5, 1'b0, 64, NV + 7};
    vecs[4] = '{3, -1, 0, 1'b1, -1, NV + 2};
    vecs[5] = '{3, 100, 3, 1'b0, -1, NV + 5};
    vecs[6] = '{3, 0, 2, 1'b0, -1, NV + 4};
    foreach (vecs[i]) if (vecs[i].exp_ones < 0) vecs[i].exp_ones = ref_ones(3, NV);

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; stall = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("start_with_abort_ignored", busy, 0);

    foreach (vecs[i]) begin
      mode = vecs[i].mode;
      run_sweep(vecs[i].stall_at, vecs[i].stall_len, vecs[i].start_mid, lat, n_we);
      check("vec_latency", lat, vecs[i].exp_lat);
      check("vec_strobes", n_we, NV);
      check("vec_ones", ones_count, vecs[i].exp_ones);
      check("vec_sig", sig, ref_sig(mode));
      @(negedge clk);
      check("vec_x_back_0", core_x, 0);
      check("vec_idle", busy, 0);
      check("vec_done_1cyc", done, 0);
    end

    // Abort at vector 10: partial results kept, no done, then a clean restart.
    mode = 3;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_x(10);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_x", core_x, 0);
    check("abort_partial_ones", ones_count, ref_ones(3, 10));
    dcnt = 0;
    repeat (20) begin
      if (done) dcnt++;
      @(negedge clk);
    end
    check("abort_no_done", dcnt, 0);
    run_sweep(-1, 0, 1'b0, lat, n_we);
    full_result_checks("after_abort", lat, n_we, NV + 2);

    // Reset at vector 77, then a full sweep.
    mode = 1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_x(77);
    rst_n = 1'b0;
    @(negedge clk);
    check_all_zero("midreset");
    rst_n = 1'b1;
    dcnt = 0;
    repeat (5) begin
      if (done) dcnt++;
      @(negedge clk);
    end
    check("midreset_no_done", dcnt, 0);
    run_sweep(-1, 0, 1'b0, lat, n_we);
    full_result_checks("after_reset", lat, n_we, NV + 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
